// File: rtl/solver_loader.sv
// solver_loader: turns a host byte packet (limb count, iteration limit,
// complex limb pairs) into solver write strobes and a run request, then
// returns the solver's 16-bit iteration count to the host as two bytes.
module solver_loader #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  real_data,
  output logic [LIMB_SIZE_BITS-1:0]  imag_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data
);

  typedef enum logic [2:0] {
    HDR_L   = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    LIMB_RE = 3'd3,
    LIMB_IM = 3'd4,
    RUN     = 3'd5,
    SEND_HI = 3'd6,
    SEND_LO = 3'd7
  } state_t;

  localparam logic [LIMB_INDEX_BITS-1:0] CNT_ONE = {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};

  state_t                     state_r;
  state_t                     state_next_s;
  logic                       accept_s;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt_r;
  logic [7:0]                 iter_hi_r;
  logic [LIMB_SIZE_BITS-1:0]  re_buf_r;
  logic [7:0]                 res_lo_r;

  // Ready only in the byte-receiving states, and forced low while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      case (state_r)
        HDR_L, HDR_HI, HDR_LO, LIMB_RE, LIMB_IM: in_ready = 1'b1;
        default:                                 in_ready = 1'b0;
      endcase
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s = in_valid & in_ready;

  // Next-state decode; the limb loop leaves once the counter has reached L.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HDR_L:   if (accept_s) state_next_s = HDR_HI;  else state_next_s = state_r;
      HDR_HI:  if (accept_s) state_next_s = HDR_LO;  else state_next_s = state_r;
      HDR_LO:  if (accept_s) state_next_s = LIMB_RE; else state_next_s = state_r;
      LIMB_RE: if (accept_s) state_next_s = LIMB_IM; else state_next_s = state_r;
      LIMB_IM: begin
        if (accept_s) begin
          if (limb_cnt_r == num_limbs_data) state_next_s = RUN;
          else                              state_next_s = LIMB_RE;
        end else begin
          state_next_s = state_r;
        end
      end
      RUN:     if (out_ready) state_next_s = SEND_HI; else state_next_s = state_r;
      SEND_HI: if (res_ready) state_next_s = SEND_LO; else state_next_s = state_r;
      SEND_LO: if (res_ready) state_next_s = HDR_L;   else state_next_s = state_r;
      default: state_next_s = HDR_L;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= HDR_L;
    else        state_r <= state_next_s;
  end

  // Registered outputs and datapath: one-cycle strobes, held data, result bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_index        <= '0;
      real_data       <= '0;
      imag_data       <= '0;
      wr_num_limbs_en <= 1'b0;
      num_limbs_data  <= '0;
      wr_iter_lim_en  <= 1'b0;
      iter_lim_data   <= 16'h0000;
      start           <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= 8'h00;
      limb_cnt_r      <= '0;
      iter_hi_r       <= 8'h00;
      re_buf_r        <= '0;
      res_lo_r        <= 8'h00;
    end else begin
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      case (state_r)
        HDR_L: begin
          if (accept_s) begin
            num_limbs_data  <= in_data[LIMB_INDEX_BITS-1:0];
            wr_num_limbs_en <= 1'b1;
          end
        end
        HDR_HI: begin
          if (accept_s) iter_hi_r <= in_data;
        end
        HDR_LO: begin
          if (accept_s) begin
            iter_lim_data  <= {iter_hi_r, in_data};
            wr_iter_lim_en <= 1'b1;
            limb_cnt_r     <= '0;
          end
        end
        LIMB_RE: begin
          if (accept_s) re_buf_r <= in_data[LIMB_SIZE_BITS-1:0];
        end
        LIMB_IM: begin
          if (accept_s) begin
            wr_real_en <= 1'b1;
            wr_imag_en <= 1'b1;
            wr_index   <= limb_cnt_r;
            real_data  <= re_buf_r;
            imag_data  <= in_data[LIMB_SIZE_BITS-1:0];
            // Counter stops at L so a full-range packet never wraps.
            if (limb_cnt_r != num_limbs_data) limb_cnt_r <= limb_cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          // start rises the cycle after the last limb strobe and drops once the solver is done.
          if (out_ready) begin
            start     <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= iterations[15:8];
            res_lo_r  <= iterations[7:0];
          end else begin
            start <= 1'b1;
          end
        end
        SEND_HI: begin
          if (res_ready) res_data <= res_lo_r;
        end
        SEND_LO: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/solver_loader.md
SOLVER_LOADER -- requirements
Module: solver_loader

Interface
REQ-001 Parameter LIMB_INDEX_BITS, default 6, width of limb index and num_limbs fields.
REQ-002 Parameter LIMB_SIZE_BITS, default 8, limb width; only the value 8 is supported.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host byte stream valid.
REQ-006 in_ready  output  1  loader accepts in_data when in_valid&in_ready at rising edge.
REQ-007 in_data  input  8  host byte.
REQ-008 wr_real_en, wr_imag_en  output  1 each  limb write strobes to solver.
REQ-009 wr_index  output  LIMB_INDEX_BITS  limb index for the write.
REQ-010 real_data, imag_data  output  LIMB_SIZE_BITS each  limb values.
REQ-011 wr_num_limbs_en  output  1; num_limbs_data  output  LIMB_INDEX_BITS.
REQ-012 wr_iter_lim_en  output  1; iter_lim_data  output  16.
REQ-013 start  output  1  solver run request.
REQ-014 out_ready  input  1  solver done; iterations  input  16  solver result.
REQ-015 res_valid  output  1; res_ready  input  1; res_data  output  8  result byte stream to host.

Function
REQ-016 Packet: byte0 = L (low LIMB_INDEX_BITS bits used, upper bits ignored); byte1 = iter_lim[15:8]; byte2 = iter_lim[7:0]; then L+1 limb pairs (re byte, im byte) for indices 0..L in order.
REQ-017 States: HDR_L, HDR_HI, HDR_LO, LIMB_RE, LIMB_IM, RUN, SEND_HI, SEND_LO; reset state HDR_L.
REQ-018 in_ready = 1 exactly in HDR_L, HDR_HI, HDR_LO, LIMB_RE, LIMB_IM; 0 in RUN, SEND_HI, SEND_LO.
REQ-019 Byte accepted in HDR_L at edge k: num_limbs_data = L and wr_num_limbs_en = 1 for cycle k+1 only; next state HDR_HI.
REQ-020 Byte accepted in HDR_LO at edge k: iter_lim_data = {hi,lo} and wr_iter_lim_en = 1 for cycle k+1 only; limb counter cleared to 0; next state LIMB_RE.
REQ-021 LIMB_RE accept: re byte buffered, no write; next LIMB_IM.
REQ-022 LIMB_IM accept at edge k: wr_real_en = wr_imag_en = 1 for cycle k+1 only, with wr_index = counter, real_data = buffered re, imag_data = accepted byte; all stable during that cycle.
REQ-023 After a LIMB_IM accept: if counter == L go to RUN, else increment counter, go to LIMB_RE; counter never wraps (max L = 2^LIMB_INDEX_BITS-1 yields indices 0..max).
REQ-024 Entering RUN: start = 1 from the cycle after the final limb write strobe (strobe and start never high together), held until out_ready sampled high.
REQ-025 In RUN with out_ready = 1 at edge k: iterations captured, start = 0 from cycle k+1, next SEND_HI.
REQ-026 out_ready outside RUN is ignored; no capture, no state change.
REQ-027 SEND_HI: res_valid = 1, res_data = captured[15:8]; on res_ready go SEND_LO. SEND_LO: res_data = captured[7:0]; on res_ready go HDR_L.
REQ-028 res_valid/res_data held stable while res_ready = 0; res_valid = 0 in all other states.
REQ-029 All write strobes are single-cycle pulses; data outputs hold last value between pulses.
REQ-030 in_valid low in any input state stalls with no outputs changing.

Reset
REQ-031 reset low: immediately state HDR_L, counter 0, all strobes, start, res_valid = 0, in_ready = 0 while reset low; all data outputs 0.
REQ-032 Reset mid-packet or mid-run discards partial packet and captured result; first byte after release is treated as byte0.
REQ-033 in_ready = 1 in the first cycle after reset release.

Verification
REQ-034 Bytes 02,00,0A,00,00,40,C0,00,00 with in_valid always 1 -> num_limbs 2 pulse, iter_lim 0x000A pulse, writes idx0 (00,00), idx1 (40,C0), idx2 (00,00), then start = 1.
REQ-035 Same packet, model asserts out_ready with iterations 0x000A after 20 cycles -> start drops next cycle; res_data 00 then 0A; back to HDR_L.
REQ-036 res_ready held 0 for 5 cycles in SEND_HI -> res_valid stays 1, res_data stays stable, no byte lost.
REQ-037 Random in_valid gaps on packet L=0 -> exactly one limb write, idx0, then start; no extra strobes during gaps.
REQ-038 out_ready pulsed during HDR_HI, and reset asserted during LIMB_IM of idx1 -> no capture; after reset, full new packet loads correctly from index 0.
REQ-039 Byte0 = FF with LIMB_INDEX_BITS = 6 -> num_limbs_data = 63; 64 limb writes indices 0..63, no wrap.
